interrupt_controller: RTL and testbench

Collects peripheral interrupt requests and one non-maskable source, latches them as pending flags, and presents the single highest-priority request to the CPU. It drives the CPU `NMI`, `INT` and `IntAddrLSBs` inputs and consumes the CPU `INTACK` output. It sits directly upstream of the CPU interrupt unit, which forms the fetch address `0xFF80 + 2*IntAddrLSBs`.

---
 rtl/interrupt_controller_pkg.sv | 14 +
 rtl/interrupt_controller_priority_encoder.sv | 24 ++
 rtl/interrupt_controller.sv | 114 +++++++++++
 tb/tb_interrupt_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants and FSM encoding for the interrupt controller.
// Pure declarations: no latency, no backpressure.
// Vector indices select the fetch address 0xFF80 + 2*index.
package interrupt_controller_pkg;

    localparam logic [5:0] NMI_VEC_LSB   = 6'd62;
    localparam logic [5:0] RESET_VEC_LSB = 6'd63;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_ACK  = 1'b1
    } ic_state_t;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Highest-index-wins priority encoder over the masked pending vector.
// Purely combinational, zero latency.
// No backpressure: the result is sampled by the owning FSM.
module irq_priority_encoder #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches edge-triggered interrupt requests and presents the highest-priority one to the CPU.
// Request edge to INT/NMI takes 2 cycles; irq_en changes show up after 1 cycle.
// While INTACK is high the vector is frozen and INT/NMI stay low; sources keep pending meanwhile.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                 NUM_SRC  = 16,
    parameter int                 VEC_BASE = 44,
    parameter logic [NUM_SRC-1:0] AUTOCLR  = '1
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic [NUM_SRC-1:0] irq_clr,
    input  logic               nmi_src,
    input  logic               INTACK,
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    output logic [NUM_SRC-1:0] irq_pend
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    ic_state_t          state, state_nxt;
    logic [NUM_SRC-1:0] prev_src;
    logic               prev_nmi;
    logic [NUM_SRC-1:0] pend, pend_nxt;
    logic               nmi_pend, nmi_pend_nxt;
    logic               int_nxt, nmi_nxt;
    logic [5:0]         vec_nxt;
    logic [IW-1:0]      grant_idx, grant_nxt;
    logic [NUM_SRC-1:0] ack_mask;
    logic               nmi_clr;
    logic               win_vld;
    logic [IW-1:0]      win_idx;

    irq_priority_encoder #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .req   (pend & irq_en),
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt = state;
        int_nxt   = 1'b0;
        nmi_nxt   = 1'b0;
        vec_nxt   = IntAddrLSBs;
        grant_nxt = grant_idx;
        ack_mask  = '0;
        nmi_clr   = 1'b0;
        case (state)
            IC_IDLE: begin
                if (INTACK) begin
                    // The grant is whatever is currently presented; a spurious ack clears nothing.
                    state_nxt = IC_ACK;
                    if (NMI) begin
                        nmi_clr = 1'b1;
                    end else if (INT) begin
                        ack_mask[grant_idx] = AUTOCLR[grant_idx];
                    end
                end else begin
                    nmi_nxt = nmi_pend;
                    int_nxt = ~nmi_pend & win_vld;
                    if (nmi_pend) begin
                        vec_nxt = NMI_VEC_LSB;
                    end else if (win_vld) begin
                        vec_nxt   = 6'(VEC_BASE) + 6'(win_idx);
                        grant_nxt = win_idx;
                    end
                end
            end
            IC_ACK: begin
                if (!INTACK) begin
                    state_nxt = IC_IDLE;
                end
            end
            default: state_nxt = IC_IDLE;
        endcase

        // New edges are ORed in last so a same-cycle set beats any clear.
        pend_nxt     = (pend & ~(irq_clr | ack_mask)) | (irq_src & ~prev_src);
        nmi_pend_nxt = (nmi_pend & ~nmi_clr) | (nmi_src & ~prev_nmi);
    end

    always_ff @(posedge MCLK) begin
        prev_src <= irq_src;
        prev_nmi <= nmi_src;
        if (reset) begin
            state       <= IC_IDLE;
            pend        <= '0;
            nmi_pend    <= 1'b0;
            INT         <= 1'b0;
            NMI         <= 1'b0;
            IntAddrLSBs <= RESET_VEC_LSB;
            grant_idx   <= '0;
        end else begin
            state       <= state_nxt;
            pend        <= pend_nxt;
            nmi_pend    <= nmi_pend_nxt;
            INT         <= int_nxt;
            NMI         <= nmi_nxt;
            IntAddrLSBs <= vec_nxt;
            grant_idx   <= grant_nxt;
        end
    end

    assign irq_pend = pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller: stimulus queues expected
// outputs per cycle, a negedge monitor compares them when their cycle arrives.
module tb_interrupt_controller;

    logic        MCLK = 1'b0;
    logic        reset;
    logic [15:0] irq_src;
    logic [15:0] irq_en;
    logic [15:0] irq_clr;
    logic        nmi_src;
    logic        INTACK;
    logic        NMI;
    logic        INT;
    logic [5:0]  IntAddrLSBs;
    logic [15:0] irq_pend;

    interrupt_controller #(
        .NUM_SRC  (16),
        .VEC_BASE (44),
        .AUTOCLR  (16'hFFEF)
    ) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .irq_src     (irq_src),
        .irq_en      (irq_en),
        .irq_clr     (irq_clr),
        .nmi_src     (nmi_src),
        .INTACK      (INTACK),
        .NMI         (NMI),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs),
        .irq_pend    (irq_pend)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        int          cyc;
        logic        i;
        logic        n;
        logic [5:0]  v;
        logic [15:0] p;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic chk(input int dly, input string nm, input logic ei, input logic en,
                       input logic [5:0] ev, input logic [15:0] ep);
        exp_t e;
        e.cyc = cyc + dly;
        e.i   = ei;
        e.n   = en;
        e.v   = ev;
        e.p   = ep;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    always @(negedge MCLK) begin
        int   k;
        exp_t e;
        k = 0;
        while (k < exp_q.size()) begin
            if (exp_q[k].cyc == cyc) begin
                e = exp_q[k];
                total++;
                if (INT !== e.i || NMI !== e.n || IntAddrLSBs !== e.v || irq_pend !== e.p) begin
                    bad++;
                    $display("FAIL %s: got INT=%0b NMI=%0b vec=%0d pend=%h, want INT=%0b NMI=%0b vec=%0d pend=%h",
                             name_q[k], INT, NMI, IntAddrLSBs, irq_pend, e.i, e.n, e.v, e.p);
                end
                exp_q.delete(k);
                name_q.delete(k);
            end else begin
                k++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        irq_src = 16'h0008;
        irq_en  = 16'h0000;
        irq_clr = 16'h0000;
        nmi_src = 1'b0;
        INTACK  = 1'b0;
        step(3);

        // Reset with source 3 held high: no edge, reset vector presented.
        chk(1, "rst_hold", 0, 0, 6'h3F, 16'h0000);
        step(1);
        reset = 1'b0;
        chk(1, "rst_rel", 0, 0, 6'h3F, 16'h0000);
        chk(3, "rst_rel3", 0, 0, 6'h3F, 16'h0000);
        step(3);
        total++;
        if (irq_pend !== 16'h0000 || INT !== 1'b0 || NMI !== 1'b0 || IntAddrLSBs !== 6'h3F) begin
            bad++;
            $display("FAIL rst_direct: INT=%0b NMI=%0b vec=%0d pend=%h", INT, NMI, IntAddrLSBs, irq_pend);
        end

        // Single source 5 pulse, then a 3-cycle acknowledge.
        irq_en     = 16'h0020;
        irq_src[5] = 1'b1;
        chk(1, "a_pend", 0, 0, 6'h3F, 16'h0020);
        chk(2, "a_int", 1, 0, 6'd49, 16'h0020);
        step(1);
        irq_src[5] = 1'b0;
        step(1);
        INTACK = 1'b1;
        chk(1, "a_ack1", 0, 0, 6'd49, 16'h0000);
        chk(2, "a_ack2", 0, 0, 6'd49, 16'h0000);
        chk(3, "a_ack3", 0, 0, 6'd49, 16'h0000);
        step(3);
        INTACK = 1'b0;
        chk(1, "a_rel", 0, 0, 6'd49, 16'h0000);
        chk(2, "a_idle", 0, 0, 6'd49, 16'h0000);
        step(3);

        // Sources 2 and 9 pending, then NMI overrides.
        irq_en     = 16'h0224;
        irq_src[2] = 1'b1;
        irq_src[9] = 1'b1;
        chk(1, "b_pend", 0, 0, 6'd49, 16'h0204);
        chk(2, "b_int9", 1, 0, 6'd53, 16'h0204);
        step(1);
        irq_src[2] = 1'b0;
        irq_src[9] = 1'b0;
        step(2);
        nmi_src = 1'b1;
        chk(1, "b_nmi_lat", 1, 0, 6'd53, 16'h0204);
        chk(2, "b_nmi", 0, 1, 6'd62, 16'h0204);
        step(1);
        nmi_src = 1'b0;
        step(1);
        INTACK = 1'b1;
        chk(1, "b_nmi_ack", 0, 0, 6'd62, 16'h0204);
        step(1);
        INTACK = 1'b0;
        chk(1, "b_nmi_rel", 0, 0, 6'd62, 16'h0204);
        chk(2, "b_53", 1, 0, 6'd53, 16'h0204);
        step(2);
        INTACK = 1'b1;
        chk(1, "b_ack53", 0, 0, 6'd53, 16'h0004);
        step(1);
        INTACK = 1'b0;
        chk(1, "b_rel53", 0, 0, 6'd53, 16'h0004);
        chk(2, "b_46", 1, 0, 6'd46, 16'h0004);
        step(2);
        INTACK = 1'b1;
        chk(1, "b_ack46", 0, 0, 6'd46, 16'h0000);
        step(1);
        INTACK = 1'b0;
        chk(2, "b_empty", 0, 0, 6'd46, 16'h0000);
        step(3);

        // Source 4 does not auto-clear on acknowledge.
        irq_en     = 16'h0234;
        irq_src[4] = 1'b1;
        chk(1, "c_pend", 0, 0, 6'd46, 16'h0010);
        chk(2, "c_int", 1, 0, 6'd48, 16'h0010);
        step(1);
        irq_src[4] = 1'b0;
        step(1);
        INTACK = 1'b1;
        chk(1, "c_ack_hold", 0, 0, 6'd48, 16'h0010);
        step(1);
        INTACK = 1'b0;
        chk(1, "c_rel", 0, 0, 6'd48, 16'h0010);
        chk(2, "c_reint", 1, 0, 6'd48, 16'h0010);
        step(2);
        irq_clr[4] = 1'b1;
        chk(1, "c_clr", 1, 0, 6'd48, 16'h0000);
        chk(2, "c_drop", 0, 0, 6'd48, 16'h0000);
        step(1);
        irq_clr = 16'h0000;
        step(2);

        // Set beats clear; disabled pending source stays silent until enabled.
        irq_src[7] = 1'b1;
        irq_clr[7] = 1'b1;
        chk(1, "d_set_wins", 0, 0, 6'd48, 16'h0080);
        chk(2, "d_masked", 0, 0, 6'd48, 16'h0080);
        step(1);
        irq_src[7] = 1'b0;
        irq_clr    = 16'h0000;
        step(2);
        irq_en = 16'h02B4;
        chk(1, "d_en", 1, 0, 6'd51, 16'h0080);
        step(2);

        // Reset in the middle of an acknowledge with source 1 pending.
        irq_src[1] = 1'b1;
        INTACK     = 1'b1;
        chk(1, "e_ack", 0, 0, 6'd51, 16'h0002);
        step(1);
        irq_src[1] = 1'b0;
        step(1);
        reset = 1'b1;
        chk(1, "e_reset", 0, 0, 6'h3F, 16'h0000);
        step(1);
        reset  = 1'b0;
        INTACK = 1'b0;
        chk(1, "e_post", 0, 0, 6'h3F, 16'h0000);
        step(1);
        irq_src[5] = 1'b1;
        chk(1, "e_pend5", 0, 0, 6'h3F, 16'h0020);
        chk(2, "e_int5", 1, 0, 6'd49, 16'h0020);
        step(1);
        irq_src[5] = 1'b0;

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) step(1);
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: expectation never reached its cycle (due %0d, now %0d)",
                     name_q[0], exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end

        if (total < 12) begin
            bad++;
            $display("FAIL coverage: only %0d checks ran", total);
        end
        if (bad != 0) begin
            $display("FAIL summary: %0d of %0d checks failed", bad, total);
        end else begin
            $display("PASS: all %0d checks passed", total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
